ppu_line_doubler: RTL and testbench

//  Downstream of the PPU pixel output, upstream of the video encoder. Captures each
//  PPU scanline (pixel/pixel_en) into ping-pong line RAMs and replays it 2x horizontal,
//  2x vertical (256x240 -> 512x480) as a valid/ready stream with line/frame markers.

---
 rtl/ppu_line_doubler.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ppu_line_doubler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_line_doubler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ppu_line_doubler
// Purpose  : Captures each PPU scanline into a pair of ping-pong line RAMs
//            and replays it doubled in both directions (every pixel twice,
//            every line twice). The result is a valid/ready stream with
//            start-of-line and start-of-frame markers for the video encoder.
//            Everything runs in a single clock domain (clk_ppu).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   H_PIXELS  pixels per captured line (line RAM depth)
//   V_LINES   captured lines per frame; later lines are ignored until vblank
//   DATA_W    pixel width
// Ports
//   clk        in   pixel clock (clk_ppu)
//   rst        in   reset, asynchronous assert, active-low
//   pixel      in   PPU pixel, sampled while pixel_en=1
//   pixel_en   in   one pixel per cycle while high
//   frame      in   PPU vblank level; a rising edge ends the frame
//   out_data   out  replayed pixel
//   out_valid  out  out_data/out_sol/out_sof/out_dim are valid
//   out_ready  in   consumer accept; a transfer is out_valid & out_ready
//   out_sol    out  first pixel of an output line
//   out_sof    out  first pixel of output line 0 of a frame
//   out_dim    out  pixel belongs to the second vertical repeat
//   ovf        out  sticky: a completed line was dropped (both banks busy)
// Configuration
//   PPU_LINE_DIM_EN  when defined, out_dim flags every pixel of the repeated
//                    line so the encoder can dim it. When undefined,
//                    out_dim is tied to 0.
// ============================================================================
module ppu_line_doubler #(
    parameter int H_PIXELS = 256,
    parameter int V_LINES  = 240,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pixel,
    input  logic              pixel_en,
    input  logic              frame,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sol,
    output logic              out_sof,
    output logic              out_dim,
    output logic              ovf
);

    localparam int c_PTR_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int c_LCTR_W = $clog2(V_LINES + 1);
    localparam int c_AW     = c_PTR_W + 1;
    localparam int c_DEPTH  = 2 ** c_AW;

    localparam logic [c_PTR_W-1:0]  c_PTR_LAST   = c_PTR_W'(H_PIXELS - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ZERO   = {c_PTR_W{1'b0}};
    localparam logic [c_LCTR_W-1:0] c_LINE_LIMIT = c_LCTR_W'(V_LINES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage: both banks share one array, addressed as {bank, pixel}
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

    // Capture side
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic                r_wr_bank;
    logic [c_LCTR_W-1:0] r_line_ctr;
    logic                r_frame_d;
    logic                r_sof_pending;
    logic [1:0]          r_bank_full;
    logic [1:0]          r_bank_sof;
    logic                r_ovf;

    // Replay side
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rd_bank;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic                r_rep_h;
    logic                r_rep_v;
    logic [DATA_W-1:0]   r_cur;
    logic [DATA_W-1:0]   r_pref;

    // Combinational control
    logic                w_frame_rise;
    logic                w_cap;
    logic                w_line_done;
    logic                w_xfer;
    logic                w_free;
    logic                w_tgt_busy;
    logic                w_we;
    logic                w_commit;
    logic [c_PTR_W-1:0]  w_rd_next;
    logic [c_AW-1:0]     w_rd_addr;
    logic [1:0]          w_full_nxt;
    logic [1:0]          w_sof_nxt;

    // ------------------------------------------------------------------
    // Capture control
    // ------------------------------------------------------------------
    // The frame edge takes priority over a pixel that arrives on the same
    // cycle, so a new frame always starts from pixel 0.
    assign w_frame_rise = frame & ~r_frame_d;
    assign w_cap        = pixel_en & (r_line_ctr != c_LINE_LIMIT) & ~w_frame_rise;
    assign w_line_done  = w_cap & (r_wr_ptr == c_PTR_LAST);

    assign w_xfer = out_valid & out_ready;

    // The bank is released on the last transfer of the second vertical repeat.
    assign w_free = (r_state == S_STREAM) & w_xfer & r_rep_h & r_rep_v &
                    (r_rd_ptr == c_PTR_LAST);

    // A bank released on this cycle counts as free. This lets a completed
    // line land in it without being reported as an overflow.
    assign w_tgt_busy = r_bank_full[r_wr_bank] & ~(w_free & (r_rd_bank == r_wr_bank));

    // A full bank is never written, so the line waiting in it (or being
    // replayed from it) is kept intact while the incoming line is dropped.
    assign w_we     = w_cap & ~w_tgt_busy;
    assign w_commit = w_line_done & ~w_tgt_busy;

    always_comb begin
        w_full_nxt = r_bank_full;
        w_sof_nxt  = r_bank_sof;
        if (w_free) begin
            w_full_nxt[r_rd_bank] = 1'b0;
            w_sof_nxt[r_rd_bank]  = 1'b0;
        end
        if (w_commit) begin
            w_full_nxt[r_wr_bank] = 1'b1;
            w_sof_nxt[r_wr_bank]  = r_sof_pending;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr      <= c_PTR_ZERO;
            r_wr_bank     <= 1'b0;
            r_line_ctr    <= '0;
            r_frame_d     <= 1'b0;
            r_sof_pending <= 1'b1;
            r_bank_full   <= 2'b00;
            r_bank_sof    <= 2'b00;
            r_ovf         <= 1'b0;
        end else begin
            r_frame_d   <= frame;
            r_bank_full <= w_full_nxt;
            r_bank_sof  <= w_sof_nxt;
            if (w_frame_rise) begin
                // Any partial line is abandoned. Lines already committed
                // keep their banks and are still replayed.
                r_wr_ptr      <= c_PTR_ZERO;
                r_line_ctr    <= '0;
                r_sof_pending <= 1'b1;
            end else if (w_cap) begin
                if (w_line_done) begin
                    r_wr_ptr   <= c_PTR_ZERO;
                    r_line_ctr <= r_line_ctr + 1'b1;
                    if (w_commit) begin
                        r_wr_bank     <= ~r_wr_bank;
                        r_sof_pending <= 1'b0;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line RAM write port and prefetch read port
    // ------------------------------------------------------------------
    // While streaming, the RAM continually reads the pixel after the one
    // currently presented. That value is therefore ready in r_pref by the
    // time the second horizontal copy is accepted, so the stream has no
    // bubbles. At the last pixel the read wraps to pixel 0, which the
    // second vertical repeat needs next.
    assign w_rd_next = (r_rd_ptr == c_PTR_LAST) ? c_PTR_ZERO : r_rd_ptr + 1'b1;
    assign w_rd_addr = (r_state == S_STREAM) ? {r_rd_bank, w_rd_next}
                                             : {r_rd_bank, c_PTR_ZERO};

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{r_wr_bank, r_wr_ptr}] <= pixel;
        end
        if (r_state == S_STREAM) begin
            r_pref <= r_mem[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Replay FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_free) begin
                    // A line committed on this cycle into the other bank
                    // is picked up directly.
                    w_state_nxt = w_full_nxt[~r_rd_bank] ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_bank <= 1'b0;
            r_rd_ptr  <= c_PTR_ZERO;
            r_rep_h   <= 1'b0;
            r_rep_v   <= 1'b0;
            r_cur     <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_rd_ptr <= c_PTR_ZERO;
                    r_rep_h  <= 1'b0;
                    r_rep_v  <= 1'b0;
                    r_cur    <= r_mem[w_rd_addr];
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        r_rep_h <= ~r_rep_h;
                        if (r_rep_h) begin
                            r_rd_ptr <= w_rd_next;
                            if (r_rd_ptr != c_PTR_LAST) begin
                                r_cur <= r_pref;
                            end else if (!r_rep_v) begin
                                // r_pref holds pixel 0 again here
                                r_rep_v <= 1'b1;
                                r_cur   <= r_pref;
                            end else begin
                                r_rep_v   <= 1'b0;
                                r_rd_bank <= ~r_rd_bank;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registers, so they stay stable under stall
    // ------------------------------------------------------------------
    assign out_valid = (r_state == S_STREAM);
    assign out_data  = r_cur;
    assign out_sol   = out_valid & (r_rd_ptr == c_PTR_ZERO) & ~r_rep_h;
    assign out_sof   = out_sol & ~r_rep_v & r_bank_sof[r_rd_bank];
    assign ovf       = r_ovf;

`ifdef PPU_LINE_DIM_EN
    assign out_dim = out_valid & r_rep_v;
`else
    assign out_dim = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppu_line_doubler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ppu_line_doubler
// Purpose  : Scoreboard bench for ppu_line_doubler. Expected beats are
//            queued when a line is issued; a monitor compares them on every
//            transfer and checks that the outputs hold steady under stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_line_doubler;

    localparam int c_H  = 256;
    localparam int c_DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [c_DW-1:0] pixel = '0;
    logic            pixel_en = 1'b0;
    logic            frame = 1'b0;
    logic [c_DW-1:0] out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_sol;
    logic            out_sof;
    logic            out_dim;
    logic            ovf;

    ppu_line_doubler #(
        .H_PIXELS (c_H),
        .V_LINES  (240),
        .DATA_W   (c_DW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .pixel     (pixel),
        .pixel_en  (pixel_en),
        .frame     (frame),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sol   (out_sol),
        .out_sof   (out_sof),
        .out_dim   (out_dim),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sol;
        logic       sof;
        logic       dim;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    beat_no  = 0;

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'(255 - i);
            2:       return 8'hC3;
            3:       return 8'hAA;
            4:       return 8'h11;
            5:       return 8'(i + 3);
            default: return 8'hF0 ^ 8'(i);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected stream for one captured line: pixel pairs, line repeated twice
    task automatic push_line(input int kind, input bit sof);
        beat_t b;
        for (int v = 0; v < 2; v++) begin
            for (int p = 0; p < c_H; p++) begin
                for (int h = 0; h < 2; h++) begin
                    b.d   = pat(kind, p);
                    b.sol = (p == 0) && (h == 0);
                    b.sof = sof && (v == 0) && (p == 0) && (h == 0);
`ifdef PPU_LINE_DIM_EN
                    b.dim = (v == 1);
`else
                    b.dim = 1'b0;
`endif
                    sb.push_back(b);
                end
            end
        end
    endtask

    task automatic send_line(input int kind);
        for (int i = 0; i < c_H; i++) begin
            pixel_en = 1'b1;
            pixel    = pat(kind, i);
            @(posedge clk);
            #1;
        end
        pixel_en = 1'b0;
    endtask

    task automatic drain(input int budget, input bit toggle, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            if (toggle) out_ready = ~out_ready;
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s drain_timeout remaining=%0d expected=0", name, sb.size());
        end
    endtask

    // Monitor: compare every transfer, and check that stalled outputs hold
    initial begin
        beat_t cur;
        beat_t hold;
        beat_t exp;
        bit    stalled;
        stalled = 1'b0;
        hold    = '0;
        forever begin
            @(negedge clk);
            cur = {out_data, out_sol, out_sof, out_dim};
            if (rst && out_valid) begin
                if (stalled) check("stall_hold", 32'(cur), 32'(hold));
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat got=%0h expected=none", cur);
                    end else begin
                        exp = sb.pop_front();
                        check($sformatf("beat%0d", beat_no), 32'(cur), 32'(exp));
                    end
                    beat_no++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold    = cur;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_sol",   32'(out_sol),   32'd0);
        check("rst_sof",   32'(out_sof),   32'd0);
        check("rst_dim",   32'(out_dim),   32'd0);
        check("rst_ovf",   32'(ovf),       32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- 1: ramp line, free-running consumer ----------------
        out_ready = 1'b1;
        push_line(0, 1'b1);
        send_line(0);
        @(negedge clk); check("lat_c0", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_c1", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_c2", 32'(out_valid), 32'd1);
        n = 1;
        for (int i = 0; i < 1023; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("no_bubble", 32'(n), 32'd1024);
        drain(100, 1'b0, "t1");
        repeat (3) @(posedge clk);
        #1 check("t1_idle", 32'(out_valid), 32'd0);

        // ---------------- 2: toggling out_ready ----------------
        out_ready = 1'b0;
        push_line(0, 1'b0);
        send_line(0);
        drain(5000, 1'b1, "t2");
        repeat (3) @(posedge clk);
        #1 check("t2_idle", 32'(out_valid), 32'd0);

        // ---------------- 3: overflow with both banks busy ----------------
        out_ready = 1'b0;
        push_line(1, 1'b0);
        push_line(5, 1'b0);
        send_line(1);
        send_line(5);
        check("t3_ovf_before", 32'(ovf), 32'd0);
        send_line(2);
        check("t3_ovf_set", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        drain(5000, 1'b0, "t3");
        repeat (3) @(posedge clk);
        #1;
        check("t3_idle", 32'(out_valid), 32'd0);
        check("t3_ovf_sticky", 32'(ovf), 32'd1);

        // ---------------- 4: partial line discarded by frame edge ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pixel_en = 1'b1;
            pixel    = pat(4, i);
            @(posedge clk);
            #1;
        end
        pixel_en = 1'b0;
        frame    = 1'b1;
        repeat (3) @(posedge clk);
        #1 frame = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("t4_no_partial", 32'(out_valid), 32'd0);
        push_line(3, 1'b1);
        send_line(3);
        drain(3000, 1'b0, "t4");
        repeat (3) @(posedge clk);
        #1 check("t4_idle", 32'(out_valid), 32'd0);

        // ---------------- 6: asynchronous reset mid-stream ----------------
        out_ready = 1'b1;
        push_line(5, 1'b0);
        send_line(5);
        repeat (300) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_data",  32'(out_data),  32'd0);
        check("t6_sol",   32'(out_sol),   32'd0);
        check("t6_sof",   32'(out_sof),   32'd0);
        check("t6_dim",   32'(out_dim),   32'd0);
        check("t6_ovf",   32'(ovf),       32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_line(6, 1'b1);
        send_line(6);
        drain(3000, 1'b0, "t6");
        repeat (3) @(posedge clk);
        #1 check("t6_idle", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
